// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared funct3 size encodings and FSM state encodings for the MEM stage.
package mem_access_unit_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: store lane replication and byte enables, load lane extraction and extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] load_data,
  output logic              misaligned
);
  logic is_w, is_h, sx;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_w = funct3[1:0] == LS_W[1:0];
    is_h = funct3[1:0] == LS_H[1:0];
    sx = ~funct3[2];
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    wdata = is_w ? store_data : is_h ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    be = is_w ? 4'hf : is_h ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr;
    load_data = is_w ? rdata : is_h ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
    misaligned = is_w ? |addr : is_h & addr[0];
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/ack data-memory port and stalling upstream.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              memRead_i,
  input  logic              dataWriteEnable_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] aluOut_i,
  input  logic [DATA_W-1:0] dataB_i,
  input  logic              registerWriteEnable_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_regWrite_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);
  logic [1:0] state, lo_q, l_addr;
  logic [2:0] f3_q, l_f3;
  logic [4:0] rd_q;
  logic rwe_q, kill_q, idle, memop, go, l_mis;
  logic [DATA_W-1:0] l_wdata, l_load;
  logic [3:0] l_be;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
`else
  assign bus_err_o = 1'b0;
`endif
  assign idle = state == IDLE;
  assign memop = memRead_i | dataWriteEnable_i;
  assign go = idle & valid_i & ~flush_i;
  // Lane logic sees the incoming op in IDLE and the latched op while the transaction is open
  assign l_f3 = idle ? funct3_i : f3_q;
  assign l_addr = idle ? aluOut_i[1:0] : lo_q;
  assign stall_o = (go & memop & ~l_mis) | (state == REQ);
  assign dmem_req_o = state == REQ;
  mem_lane_align u_lane (
    .funct3(l_f3), .addr(l_addr), .store_data(dataB_i), .rdata(dmem_rdata_i),
    .wdata(l_wdata), .be(l_be), .load_data(l_load), .misaligned(l_mis)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lo_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      rwe_q <= 1'b0;
      kill_q <= 1'b0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o <= '0;
      wb_valid_o <= 1'b0;
      wb_data_o <= '0;
      wb_rd_o <= '0;
      wb_regWrite_o <= 1'b0;
      misaligned_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt <= '0;
      bus_err_o <= 1'b0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      misaligned_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (go & (~memop | l_mis)) begin
            wb_valid_o <= 1'b1;
            misaligned_o <= memop;
            wb_data_o <= aluOut_i;
            wb_rd_o <= rd_i;
            wb_regWrite_o <= registerWriteEnable_i & ~memop;
          end else if (go) begin
            state <= REQ;
            dmem_we_o <= dataWriteEnable_i;
            dmem_addr_o <= {aluOut_i[ADDR_W-1:2], 2'b00};
            dmem_be_o <= l_be;
            dmem_wdata_o <= l_wdata;
            lo_q <= aluOut_i[1:0];
            f3_q <= funct3_i;
            rd_q <= rd_i;
            rwe_q <= registerWriteEnable_i & ~dataWriteEnable_i;
            kill_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (flush_i) kill_q <= 1'b1;
          if (dmem_ack_i) begin
            state <= RESP;
            wb_valid_o <= ~(kill_q | flush_i);
            wb_data_o <= l_load;
            wb_rd_o <= rd_q;
            wb_regWrite_o <= rwe_q;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            bus_err_o <= 1'b1;
            wb_valid_o <= ~(kill_q | flush_i);
            wb_rd_o <= rd_q;
            wb_regWrite_o <= 1'b0;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench against an arithmetic load/store reference model.
module tb_mem_access_unit;
  logic clk = 0, rst = 0;
  logic valid_i = 0, flush_i = 0, memRead_i = 0, dataWriteEnable_i = 0, registerWriteEnable_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] aluOut_i = 0, dataB_i = 0, dmem_rdata_i = 0;
  logic [4:0] rd_i = 0;
  logic dmem_ack_i = 0;
  logic stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_regWrite_o, misaligned_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0] dmem_be_o;
  logic [4:0] wb_rd_o;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .memRead_i(memRead_i),
    .dataWriteEnable_i(dataWriteEnable_i), .funct3_i(funct3_i), .aluOut_i(aluOut_i), .dataB_i(dataB_i),
    .registerWriteEnable_i(registerWriteEnable_i), .rd_i(rd_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_regWrite_o(wb_regWrite_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
    return ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) || (f3 == 3'd2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input int a);
    if (f3 == 3'd2) return 4'd15;
    if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << a);
    return 4'(1 << a);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd2) return d;
    if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
    return (d % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a, input logic [31:0] r);
    logic [31:0] v;
    if (f3 == 3'd2) return r;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (r >> (8 * a)) % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      v = (r >> (8 * a)) % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end
    return v;
  endfunction

  task automatic mem_op(input logic [2:0] f3, input logic st, input logic ld, input logic [31:0] addr,
                        input logic [31:0] bdata, input logic [31:0] rdata, input int waits,
                        input logic rwe, input logic [4:0] rd);
    logic mis;
    mis = is_mis(f3, addr);
    @(negedge clk);
    valid_i = 1; flush_i = 0; memRead_i = ld; dataWriteEnable_i = st; funct3_i = f3;
    aluOut_i = addr; dataB_i = bdata; registerWriteEnable_i = rwe; rd_i = rd;
    #1;
    checks++; if (stall_o !== !mis) $display("FAIL issue_stall addr=%h got %b want %b", addr, stall_o, !mis); else passed++;
    @(posedge clk); #1;
    if (mis) begin
      valid_i = 0;
      checks++; if ({dmem_req_o, misaligned_o, wb_valid_o, wb_regWrite_o, stall_o} !== 5'b01100)
        $display("FAIL misaligned addr=%h got req/mis/wbv/rw/stall=%b want 01100", addr, {dmem_req_o, misaligned_o, wb_valid_o, wb_regWrite_o, stall_o});
      else passed++;
      @(posedge clk); #1;
      checks++; if ({misaligned_o, wb_valid_o} !== 2'b00) $display("FAIL mis_pulse got %b want 00", {misaligned_o, wb_valid_o}); else passed++;
    end else begin
      for (int w = 0; w <= waits; w++) begin
        checks++; if ({dmem_req_o, stall_o, dmem_we_o} !== {2'b11, st})
          $display("FAIL req_hold w=%0d got req/stall/we=%b want %b", w, {dmem_req_o, stall_o, dmem_we_o}, {2'b11, st});
        else passed++;
        checks++; if (dmem_addr_o !== (addr & ~32'd3) || dmem_be_o !== exp_be(f3, int'(addr % 4)))
          $display("FAIL req_addr_be got %h/%b want %h/%b", dmem_addr_o, dmem_be_o, addr & ~32'd3, exp_be(f3, int'(addr % 4)));
        else passed++;
        if (st) begin
          checks++; if (dmem_wdata_o !== exp_wdata(f3, bdata)) $display("FAIL req_wdata got %h want %h", dmem_wdata_o, exp_wdata(f3, bdata)); else passed++;
        end
        dmem_ack_i = (w == waits);
        dmem_rdata_i = (w == waits) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      dmem_ack_i = 0;
      checks++; if ({dmem_req_o, stall_o, wb_valid_o, bus_err_o} !== 4'b0010)
        $display("FAIL resp_ctl got req/stall/wbv/err=%b want 0010", {dmem_req_o, stall_o, wb_valid_o, bus_err_o});
      else passed++;
      checks++; if (wb_rd_o !== rd || wb_regWrite_o !== (rwe & !st))
        $display("FAIL resp_rd got %0d/%b want %0d/%b", wb_rd_o, wb_regWrite_o, rd, rwe & !st);
      else passed++;
      if (!st) begin
        checks++; if (wb_data_o !== exp_load(f3, int'(addr % 4), rdata))
          $display("FAIL load_data f3=%0d addr=%h got %h want %h", f3, addr, wb_data_o, exp_load(f3, int'(addr % 4), rdata));
        else passed++;
      end
      valid_i = 0;
      @(posedge clk); #1;
      checks++; if ({wb_valid_o, dmem_req_o} !== 2'b00) $display("FAIL resp_pulse got %b want 00", {wb_valid_o, dmem_req_o}); else passed++;
    end
  endtask

  task automatic test_nonmem(input logic [31:0] alu, input logic rwe, input logic [4:0] rd);
    @(negedge clk);
    valid_i = 1; flush_i = 0; memRead_i = 0; dataWriteEnable_i = 0; aluOut_i = alu; registerWriteEnable_i = rwe; rd_i = rd;
    #1;
    checks++; if (stall_o !== 1'b0) $display("FAIL nonmem_stall got %b want 0", stall_o); else passed++;
    @(posedge clk); #1;
    valid_i = 0;
    checks++; if ({wb_valid_o, wb_regWrite_o, wb_rd_o, wb_data_o, dmem_req_o} !== {1'b1, rwe, rd, alu, 1'b0})
      $display("FAIL nonmem_wb got v=%b rw=%b rd=%0d d=%h req=%b want rw=%b rd=%0d d=%h", wb_valid_o, wb_regWrite_o, wb_rd_o, wb_data_o, dmem_req_o, rwe, rd, alu);
    else passed++;
    @(posedge clk); #1;
    checks++; if (wb_valid_o !== 1'b0) $display("FAIL nonmem_pulse got %b want 0", wb_valid_o); else passed++;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_valid_o, wb_data_o, wb_rd_o, wb_regWrite_o, misaligned_o, bus_err_o} !== '0)
      $display("FAIL reset_outputs got nonzero req=%b addr=%h wb=%h", dmem_req_o, dmem_addr_o, wb_data_o);
    else passed++;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_plan_vectors();
    mem_op(3'd2, 0, 1, 32'h100, 0, 32'hDEADBEEF, 2, 1, 5'd7);
    mem_op(3'd0, 0, 1, 32'h103, 0, 32'h80123456, 1, 1, 5'd8);
    mem_op(3'd4, 0, 1, 32'h103, 0, 32'h80123456, 0, 1, 5'd9);
    mem_op(3'd1, 1, 0, 32'h102, 32'h00001234, 0, 0, 1, 5'd10);
    mem_op(3'd2, 0, 1, 32'h101, 0, 0, 0, 1, 5'd11);
    mem_op(3'd5, 0, 1, 32'h102, 0, 32'h9ABC1234, 0, 1, 5'd12);
    mem_op(3'd1, 0, 1, 32'h102, 0, 32'h9ABC1234, 3, 1, 5'd13);
  endtask

  task automatic test_flush();
    @(negedge clk);
    valid_i = 1; flush_i = 1; memRead_i = 1; dataWriteEnable_i = 0; funct3_i = 3'd2; aluOut_i = 32'h200;
    #1;
    checks++; if (stall_o !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall_o); else passed++;
    @(posedge clk); #1;
    checks++; if ({dmem_req_o, wb_valid_o} !== 2'b00) $display("FAIL flush_idle got req/wbv=%b want 00", {dmem_req_o, wb_valid_o}); else passed++;
    flush_i = 0; dataWriteEnable_i = 1; dataB_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    flush_i = 1;
    checks++; if ({dmem_req_o, dmem_we_o} !== 2'b11) $display("FAIL flush_req_start got %b want 11", {dmem_req_o, dmem_we_o}); else passed++;
    @(posedge clk); #1;
    flush_i = 0;
    checks++; if ({dmem_req_o, dmem_we_o, dmem_wdata_o} !== {2'b11, 32'hCAFEF00D}) $display("FAIL flush_req_hold got req=%b wd=%h", dmem_req_o, dmem_wdata_o); else passed++;
    dmem_ack_i = 1;
    @(posedge clk); #1;
    dmem_ack_i = 0; valid_i = 0;
    checks++; if ({dmem_req_o, wb_valid_o, stall_o} !== 3'b000) $display("FAIL flush_req_kill got req/wbv/stall=%b want 000", {dmem_req_o, wb_valid_o, stall_o}); else passed++;
    @(posedge clk); #1;
    checks++; if (wb_valid_o !== 1'b0) $display("FAIL flush_kill_late got %b want 0", wb_valid_o); else passed++;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    valid_i = 1; memRead_i = 0; dataWriteEnable_i = 1; funct3_i = 3'd2; aluOut_i = 32'h300; dataB_i = 32'h1234_5678; rd_i = 5'd3;
    @(posedge clk); #1;
    checks++; if (dmem_req_o !== 1'b1) $display("FAIL rst_req_pre got %b want 1", dmem_req_o); else passed++;
    valid_i = 0; rst = 0;
    #1;
    checks++; if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_valid_o, wb_data_o, wb_rd_o, wb_regWrite_o, misaligned_o, bus_err_o} !== '0)
      $display("FAIL rst_mid_req got req=%b we=%b addr=%h be=%b", dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o);
    else passed++;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++; if ({dmem_req_o, wb_valid_o} !== 2'b00) $display("FAIL rst_idle got %b want 00", {dmem_req_o, wb_valid_o}); else passed++;
    mem_op(3'd2, 0, 1, 32'h304, 0, 32'h0BADF00D, 0, 1, 5'd4);
  endtask

  task automatic test_random();
    logic [2:0] tbl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic st;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) test_nonmem($urandom, 1'($urandom_range(0, 1)), 5'($urandom));
      else begin
        st = 1'($urandom_range(0, 1));
        mem_op(tbl[$urandom_range(0, st ? 2 : 4)], st, st ? 1'($urandom_range(0, 1)) : 1'b1, $urandom,
               $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom));
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    valid_i = 1; flush_i = 0; memRead_i = 1; dataWriteEnable_i = 0; funct3_i = 3'd2; aluOut_i = 32'h400; registerWriteEnable_i = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({dmem_req_o, bus_err_o} !== 2'b10) $display("FAIL timeout_wait i=%0d got %b want 10", i, {dmem_req_o, bus_err_o}); else passed++;
      if (i == 3) valid_i = 0;
      @(posedge clk); #1;
    end
    checks++; if ({bus_err_o, wb_valid_o, wb_regWrite_o, dmem_req_o, stall_o} !== 5'b11000)
      $display("FAIL timeout_fire got err/wbv/rw/req/stall=%b want 11000", {bus_err_o, wb_valid_o, wb_regWrite_o, dmem_req_o, stall_o});
    else passed++;
    @(posedge clk); #1;
    checks++; if (bus_err_o !== 1'b0) $display("FAIL timeout_pulse got %b want 0", bus_err_o); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plan_vectors();
    test_nonmem(32'h1357_9BDF, 1, 5'd21);
    test_flush();
    test_reset_mid_req();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
